najla_result_serializer: RTL and testbench
==========================================

NAJLA_RESULT_SERIALIZER -- requirements
Module: najla_result_serializer

Interface
REQ-001 Parameter DEPTH, default 4, meaning result-entry FIFO depth; legal values 2, 4, 8 only.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous active-low reset; asserting it clears all state immediately, and deassertion is synchronous to clk.
REQ-004 in_valid  input  1  upstream result beat valid.
REQ-005 in_ready  output  1  block can accept a result beat this cycle.
REQ-006 in_ln_q30  input  64  signed Q30 natural-log result.
REQ-007 in_log10_q30  input  64  signed Q30 log10 result.
REQ-008 out_valid  output  1  out_data holds a valid word.
REQ-009 out_ready  input  1  downstream accepts a word this cycle.
REQ-010 out_data  output  32  serialized result word.
REQ-011 out_idx  output  2  word index within the current result (0..3).
REQ-012 out_last  output  1  high when out_idx==3 (final word of a result).
REQ-013 level  output  $clog2(DEPTH)+1  number of occupied FIFO entries.
REQ-014 result_cnt  output  32  count of fully emitted results.

Function
REQ-015 Input handshake: a beat is accepted on a posedge where in_valid && in_ready.
REQ-016 Accepted beats are stored as one 128-bit entry {in_log10_q30, in_ln_q30} in a circular FIFO of DEPTH entries, with write and read pointers wrapping modulo DEPTH.
REQ-017 in_ready = (level < DEPTH), derived from registered state only; a pop in the same cycle does not raise in_ready (no bypass when full).
REQ-018 out_valid = (level != 0).
REQ-019 Output word order per entry: idx0 = ln[31:0], idx1 = ln[63:32], idx2 = log10[31:0], idx3 = log10[63:32]; bits pass through unchanged, with no sign extension or rounding.
REQ-020 Output handshake: on out_valid && out_ready, if out_idx<3 then out_idx increments; if out_idx==3 then out_idx<=0, the head entry is popped, and result_cnt increments (wrapping at 2^32).
REQ-021 While out_valid && !out_ready, out_data, out_idx and out_last hold stable.
REQ-022 Latency: a beat accepted at posedge k makes out_valid high after posedge k when the FIFO was empty, with out_idx==0 and out_data equal to the beat's ln[31:0].
REQ-023 A simultaneous push and final-word pop in the same cycle leaves level unchanged; both pointers advance.
REQ-024 A push alone sets level+1; a final-word pop alone sets level-1; non-final word transfers do not change level.
REQ-025 Order is strictly FIFO; no entry is dropped or duplicated under any in_valid/out_ready pattern.
REQ-026 Accepted input data is never overwritten while unread; with in_ready low, in_valid is ignored.
REQ-027 Steady-state throughput: one result per 4 cycles with out_ready held high.

Reset
REQ-028 On rst_n low, the following are set: in_ready=1, out_valid=0, out_idx=0, out_last=0, level=0, result_cnt=0, and both FIFO pointers 0.
REQ-029 out_data is don't-care while out_valid=0, and it drives 0 out of reset.
REQ-030 Reset mid-result discards all buffered entries and any partially emitted result; result_cnt is not incremented for a partial result.
REQ-031 FIFO storage arrays need no reset.

Verification
REQ-032 Single beat, out_ready=1: ln=64'h0000_0001_4000_0000, log10=64'hFFFF_FFFF_C000_0000 -> words 4000_0000, 0000_0001, C000_0000, FFFF_FFFF on 4 consecutive cycles; out_last on the 4th; result_cnt=1; level returns 0.
REQ-033 Fill with out_ready=0: push 4 beats (DEPTH=4) -> level=4, in_ready=0; a 5th in_valid is not accepted; out_data holds ln[31:0] of beat 0 throughout.
REQ-034 Back-pressure: stream 1024 beats with out_ready pattern 1,1,0 repeating and in_valid always high -> all 4096 words match a reference model in order; result_cnt=1024; no stall lasts more than the back-pressure allows.
REQ-035 Simultaneous push/pop: level=2 with head at idx3, and in_valid=1 and out_ready=1 in the same cycle -> level stays 2; the next word is idx0 of the following entry.
REQ-036 Reset mid-stream: rst_n low while level=3 and out_idx=2 -> immediately out_valid=0, level=0, result_cnt=0; after release the first new beat emits from idx0.
REQ-037 Full with a final-word pop: level=4, out_idx=3, out_ready=1, in_valid=1 -> pop occurs with no push that cycle; level=3 and in_ready=1 next cycle.

Source files
------------

// File: rtl/najla_result_serializer.sv
// Buffers 128-bit {log10, ln} Q30 result pairs in a small circular FIFO.
// Each entry is emitted as four 32-bit words on a valid/ready stream.
module najla_result_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [63:0]       in_ln_q30,
    input  logic signed [63:0]       in_log10_q30,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [1:0]               out_idx,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              result_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
        $error("najla_result_serializer: DEPTH must be 2, 4 or 8");
    end

    logic [127:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [1:0]    r_idx;
    logic [31:0]   r_cnt;

    logic          w_push;
    logic          w_word_xfer;
    logic          w_pop;
    logic [127:0]  w_head;

    // Flow control comes purely from registered occupancy, so a full FIFO
    // never accepts a beat even when the head is being popped that cycle.
    assign in_ready    = (r_level < LW'(DEPTH));
    assign out_valid   = (r_level != '0);
    assign w_push      = in_valid && in_ready;
    assign w_word_xfer = out_valid && out_ready;
    assign w_pop       = w_word_xfer && (r_idx == 2'd3);
    assign w_head      = r_mem[r_rptr];

    assign out_idx    = r_idx;
    assign out_last   = out_valid && (r_idx == 2'd3);
    assign level      = r_level;
    assign result_cnt = r_cnt;

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (r_idx)
                2'd0:    out_data = w_head[31:0];
                2'd1:    out_data = w_head[63:32];
                2'd2:    out_data = w_head[95:64];
                default: out_data = w_head[127:96];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_log10_q30, in_ln_q30};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_word_xfer) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
                r_cnt  <= r_cnt + 32'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: tb/tb_najla_result_serializer.sv
// Directed bench for najla_result_serializer with a word-level scoreboard
// fed at input acceptance and drained at each output transfer.
module tb_najla_result_serializer;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [63:0] in_ln_q30;
    logic signed [63:0] in_log10_q30;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [1:0]         out_idx;
    logic               out_last;
    logic [$clog2(DEPTH):0] level;
    logic [31:0]        result_cnt;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int n_xfer = 0;

    logic [33:0] sb_q[$];

    najla_result_serializer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ln_q30    (in_ln_q30),
        .in_log10_q30 (in_log10_q30),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .level        (level),
        .result_cnt   (result_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check the DUT against the scoreboard head at the negedge,
    // account for both handshakes, then return #1 after the posedge.
    task automatic step();
        logic [33:0] e;
        @(negedge clk);
        chk("out_valid", out_valid, sb_q.size() != 0);
        if (sb_q.size() != 0) begin
            e = sb_q[0];
            chk("out_data", out_data, e[31:0]);
            chk("out_idx", out_idx, e[33:32]);
            chk("out_last", out_last, e[33:32] == 2'd3);
            if (out_valid && out_ready) begin
                void'(sb_q.pop_front());
                n_xfer++;
            end
        end
        if (rst_n && in_valid && in_ready) begin
            sb_q.push_back({2'd0, in_ln_q30[31:0]});
            sb_q.push_back({2'd1, in_ln_q30[63:32]});
            sb_q.push_back({2'd2, in_log10_q30[31:0]});
            sb_q.push_back({2'd3, in_log10_q30[63:32]});
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, sb_q.size(), 0);
    endtask

    initial begin
        int cyc;
        int stall;
        int max_stall;
        int acc0;
        logic [31:0] cnt0;
        logic [31:0] beat0_lo;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_ln_q30    = '0;
        in_log10_q30 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_level", level, 0);
        chk("rst_result_cnt", result_cnt, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, streaming out on consecutive cycles
        in_ln_q30    = 64'h0000_0001_4000_0000;
        in_log10_q30 = 64'hFFFF_FFFF_C000_0000;
        in_valid     = 1'b1;
        out_ready    = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_level", level, 1);
        chk("single_first_word", out_data, 32'h4000_0000);
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 10) begin
            step();
            cyc++;
        end
        chk("single_cycles", cyc, 4);
        chk("single_result_cnt", result_cnt, 1);
        chk("single_level_end", level, 0);

        // Fill with back-pressure
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_ln_q30    = {$urandom, $urandom};
            in_log10_q30 = {$urandom, $urandom};
            if (i == 0) beat0_lo = in_ln_q30[31:0];
            in_valid = 1'b1;
            chk("fill_in_ready", in_ready, 1);
            step();
        end
        chk("full_level", level, DEPTH);
        chk("full_in_ready", in_ready, 0);
        in_ln_q30 = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        step();
        chk("full_5th_rejected", level, DEPTH);
        chk("full_acc_count", n_acc, 1 + DEPTH);
        chk("full_head_hold", out_data, beat0_lo);

        // Full, head at idx3, final-word pop with in_valid high
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("full_idx3", out_idx, 3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fullpop_level", level, DEPTH - 1);
        chk("fullpop_in_ready", in_ready, 1);

        // Level 2, head at idx3, simultaneous push and final pop
        repeat (4) step();
        chk("sim_level_pre", level, 2);
        repeat (3) step();
        chk("sim_idx3", out_idx, 3);
        in_ln_q30    = 64'h1111_2222_3333_4444;
        in_log10_q30 = 64'h5555_6666_7777_8888;
        in_valid     = 1'b1;
        step();
        in_valid = 1'b0;
        chk("sim_level_post", level, 2);
        chk("sim_next_idx", out_idx, 0);
        drain("sim_drain", 40);
        chk("sim_result_cnt", result_cnt, 1 + 1 + DEPTH);

        // Reset while level=3 and out_idx=2
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_ln_q30    = {$urandom, $urandom};
            in_log10_q30 = {$urandom, $urandom};
            in_valid     = 1'b1;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        chk("mid_level", level, 3);
        chk("mid_idx", out_idx, 2);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("arst_out_valid", out_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_result_cnt", result_cnt, 0);
        chk("arst_idx", out_idx, 0);
        chk("arst_in_ready", in_ready, 1);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", out_valid, 0);
        in_ln_q30    = 64'hCAFE_F00D_0BAD_C0DE;
        in_log10_q30 = 64'h0123_4567_89AB_CDEF;
        in_valid     = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_idx", out_idx, 0);
        chk("post_rst_word", out_data, 32'h0BAD_C0DE);
        drain("post_rst_drain", 10);
        chk("post_rst_cnt", result_cnt, 1);

        // 1024 beats with out_ready pattern 1,1,0
        cnt0      = result_cnt;
        acc0      = n_acc;
        cyc       = 0;
        stall     = 0;
        max_stall = 0;
        while ((n_acc - acc0 < 1024 || sb_q.size() != 0) && cyc < 20000) begin
            in_valid     = (n_acc - acc0 < 1024);
            in_ln_q30    = {$urandom, $urandom};
            in_log10_q30 = {$urandom, $urandom};
            out_ready    = (cyc % 3 != 2);
            if (sb_q.size() != 0 && !out_ready) stall++;
            else stall = 0;
            if (stall > max_stall) max_stall = stall;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_beats", n_acc - acc0, 1024);
        chk("bp_sb_empty", sb_q.size(), 0);
        chk("bp_result_cnt", result_cnt - cnt0, 1024);
        chk("bp_max_stall", max_stall, 1);
        chk("bp_level_end", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
